design_select_sequencer: RTL and testbench

- Drives the 4-bit `design_select` bus that feeds the 12-way design multiplexer and chip-select/reset logic.
- Accepts selection requests from a host over a valid/ready handshake.
- Each switch-over is glitch-free: the bus is forced to 0 (no design selected, all designs held in reset) for a guard interval, then the new ID is applied, then a settle interval elapses before completion is reported.
- Out-of-range IDs are rejected, so only legal selections ever reach the mux.

---
 rtl/design_select_sequencer_if.sv | 36 +++
 rtl/design_select_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_design_select_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/design_select_sequencer_if.sv
// -----------------------------------------------------------------------------
// design_select_sequencer_if
//   Request/status bundle between a host and the design-select sequencer.
//
//   Signals:
//     req_valid     host -> seq  host presents a selection request
//     req_id[3:0]   host -> seq  requested design ID
//     req_ready     seq -> host  sequencer can accept a request
//     design_select seq -> host  registered select bus for the design mux
//     busy          seq -> host  switch-over in progress
//     done          seq -> host  one-cycle pulse at switch-over completion
//     err           seq -> host  one-cycle pulse when a request is rejected
//     cur_id[3:0]   seq -> host  last successfully applied ID
//
//   Modports: master (host side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface design_select_sequencer_if;
  logic       req_valid;
  logic [3:0] req_id;
  logic       req_ready;
  logic [3:0] design_select;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cur_id;

  modport master (
    output req_valid, req_id,
    input  req_ready, design_select, busy, done, err, cur_id
  );

  modport slave (
    input  req_valid, req_id,
    output req_ready, design_select, busy, done, err, cur_id
  );
endinterface

// File: rtl/design_select_sequencer.sv
// -----------------------------------------------------------------------------
// design_select_sequencer
//   Drives the 4-bit design_select bus feeding the design mux and the
//   chip-select/reset logic. Every switch-over first parks the bus at 0 for
//   GUARD_CYCLES cycles, then applies the new ID and waits SETTLE_CYCLES
//   cycles before pulsing done. IDs above NUM_DESIGNS are rejected with a
//   one-cycle err pulse and never reach the bus.
//
//   Ports:
//     clk    input   system clock
//     n_rst  input   synchronous active-low reset
//     bus    slave modport of design_select_sequencer_if
//            (req_valid, req_id, req_ready, design_select, busy, done, err,
//             cur_id)
//
//   Optional feature (macro DESIGN_SEQ_AUTO_SELECT_EN):
//     When defined, the sequencer issues an internal request for DEFAULT_ID
//     on the first cycle after reset, and holds req_ready low until that
//     switch-over completes. A DEFAULT_ID of 0 or above NUM_DESIGNS produces
//     no internal request. When undefined, the sequencer idles with
//     design_select=0 after reset.
// -----------------------------------------------------------------------------
module design_select_sequencer #(
  parameter int NUM_DESIGNS   = 12,
  parameter int GUARD_CYCLES  = 16,  // must be >= 1
  parameter int SETTLE_CYCLES = 8,   // must be >= 1
  parameter int DEFAULT_ID    = 0
) (
  input  logic                        clk,
  input  logic                        n_rst,
  design_select_sequencer_if.slave    bus
);

  localparam int MAX_CYC = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] GUARD_LOAD  = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [3:0]    MAX_ID      = 4'(NUM_DESIGNS);
  localparam logic [3:0]    DEF_ID      = 4'(DEFAULT_ID);

`ifdef DESIGN_SEQ_AUTO_SELECT_EN
  // Only a legal, nonzero default produces an internal request.
  localparam bit AUTO_REQ = (DEFAULT_ID != 0) && (DEFAULT_ID <= NUM_DESIGNS);
`else
  localparam bit AUTO_REQ = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    APPLY   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [3:0]    ds_q,    ds_d;
  logic [3:0]    cur_q,   cur_d;
  logic [3:0]    tgt_q,   tgt_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          err_q,   err_d;
  logic          rdy_q,   rdy_d;
  logic          auto_q,  auto_d;   // internal request pending after reset

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ds_d    = ds_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdy_d   = rdy_q;
    auto_d  = auto_q;

    case (state_q)
      IDLE: begin
        ds_d   = cur_q;
        busy_d = 1'b0;
        if (auto_q) begin
          tgt_d   = DEF_ID;
          auto_d  = 1'b0;
          state_d = QUIESCE;
          cnt_d   = GUARD_LOAD;
          ds_d    = 4'd0;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
        end else if (bus.req_valid && rdy_q) begin
          if (bus.req_id > MAX_ID) begin
            // Rejected: bus and cur_id untouched, remain ready.
            err_d = 1'b1;
            rdy_d = 1'b1;
          end else begin
            tgt_d   = bus.req_id;
            state_d = QUIESCE;
            cnt_d   = GUARD_LOAD;
            ds_d    = 4'd0;
            busy_d  = 1'b1;
            rdy_d   = 1'b0;
          end
        end else begin
          rdy_d = 1'b1;
        end
      end

      QUIESCE: begin
        ds_d = 4'd0;
        if (cnt_q == '0) begin
          if (tgt_q == 4'd0) begin
            // Deselect request completes without an APPLY phase.
            cur_d   = 4'd0;
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
          end else begin
            state_d = APPLY;
            ds_d    = tgt_q;
            cnt_d   = SETTLE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      APPLY: begin
        ds_d = tgt_q;
        if (cnt_q == '0) begin
          cur_d   = tgt_q;
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ds_d    = 4'd0;
        cur_d   = 4'd0;
        busy_d  = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ds_q    <= 4'd0;
      cur_q   <= 4'd0;
      tgt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= !AUTO_REQ;
      auto_q  <= AUTO_REQ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ds_q    <= ds_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      auto_q  <= auto_d;
    end
  end

  assign bus.req_ready     = rdy_q;
  assign bus.design_select = ds_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.cur_id        = cur_q;

endmodule

// File: tb/tb_design_select_sequencer.sv
// -----------------------------------------------------------------------------
// tb_design_select_sequencer
//   Directed, table-driven bench for design_select_sequencer with default
//   parameters (NUM_DESIGNS=12, GUARD=16, SETTLE=8). Outputs are sampled on
//   the falling edge; inputs change on the falling edge or 1 time unit after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_design_select_sequencer;

  localparam int G = 16;
  localparam int S = 8;
  localparam int LAT_SEL = G + S + 1;  // 25
  localparam int LAT_OFF = G + 1;      // 17

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  logic [3:0] model_cur;

  design_select_sequencer_if bus_if ();

  design_select_sequencer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] id;
    bit         is_err;
    int         lat;
  } vec_t;

  vec_t vecs [9];

  // Packed observation: {design_select, cur_id, busy, done, err, req_ready}
  function automatic logic [11:0] pk(input logic [3:0] ds, input logic [3:0] cur,
                                     input logic b, input logic d,
                                     input logic e, input logic r);
    return {ds, cur, b, d, e, r};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {bus_if.design_select, bus_if.cur_id, bus_if.busy,
           bus_if.done, bus_if.err, bus_if.req_ready};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got ds=%0d cur=%0d busy=%b done=%b err=%b rdy=%b, expected ds=%0d cur=%0d busy=%b done=%b err=%b rdy=%b",
               name, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Checks every cycle following an accept edge, up to and including the
  // completion (done) or rejection (err) cycle.
  task automatic check_seq(input logic [3:0] prev, input logic [3:0] id,
                           input bit is_err, input int lat, input string name);
    logic [11:0] exp;
    bit last;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (is_err) begin
        exp = pk(prev, prev, 1'b0, 1'b0, 1'b1, 1'b1);
      end else begin
        last = (k == lat);
        exp  = pk((k <= G) ? 4'd0 : id, last ? id : prev,
                  !last, last, 1'b0, last);
      end
      check($sformatf("%s_c%0d", name, k), exp);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, pk(model_cur, model_cur, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // Presents one request at a falling edge, drops it after the accept edge.
  task automatic issue(input logic [3:0] id);
    bus_if.req_valid = 1'b1;
    bus_if.req_id    = id;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  initial begin
    bit saw_done;

    checks    = 0;
    failures  = 0;
    model_cur = 4'd0;
    n_rst     = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_id    = 4'd0;

    vecs[0] = '{id: 4'd5,  is_err: 1'b0, lat: LAT_SEL};
    vecs[1] = '{id: 4'd13, is_err: 1'b1, lat: 1};
    vecs[2] = '{id: 4'd15, is_err: 1'b1, lat: 1};
    vecs[3] = '{id: 4'd3,  is_err: 1'b0, lat: LAT_SEL};
    vecs[4] = '{id: 4'd9,  is_err: 1'b0, lat: LAT_SEL};
    vecs[5] = '{id: 4'd9,  is_err: 1'b0, lat: LAT_SEL};
    vecs[6] = '{id: 4'd0,  is_err: 1'b0, lat: LAT_OFF};
    vecs[7] = '{id: 4'd12, is_err: 1'b0, lat: LAT_SEL};
    vecs[8] = '{id: 4'd1,  is_err: 1'b0, lat: LAT_SEL};

    // Reset held for three edges, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    n_rst = 1'b1;
    check_idle("reset_release_1");
    check_idle("reset_release_2");

    // Table-driven requests.
    for (int v = 0; v < 9; v++) begin
      issue(vecs[v].id);
      check_seq(model_cur, vecs[v].id, vecs[v].is_err, vecs[v].lat,
                $sformatf("vec%0d_id%0d", v, vecs[v].id));
      if (!vecs[v].is_err) model_cur = vecs[v].id;
      check_idle($sformatf("vec%0d_idle", v));
    end

    // Busy: request 7, then keep req_valid high with req_id=2 throughout.
    bus_if.req_valid = 1'b1;
    bus_if.req_id    = 4'd7;
    @(posedge clk);
    #1;
    bus_if.req_id = 4'd2;
    check_seq(model_cur, 4'd7, 1'b0, LAT_SEL, "busy_7");
    model_cur = 4'd7;
    @(posedge clk);  // held request for 2 is accepted on this edge
    #1;
    bus_if.req_valid = 1'b0;
    check_seq(model_cur, 4'd2, 1'b0, LAT_SEL, "held_2");
    model_cur = 4'd2;
    check_idle("held_2_idle");

    // Reset during APPLY of a request for 4.
    issue(4'd4);
    repeat (20) @(negedge clk);
    check("rst_apply_pre", pk(4'd4, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_apply_post", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    model_cur = 4'd0;
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus_if.done || bus_if.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL rst_apply_no_done: got done/busy activity=1, expected 0");
    end
    check("rst_apply_idle", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));

    // Reset during QUIESCE of a request for 6.
    issue(4'd6);
    repeat (5) @(negedge clk);
    check("rst_quiesce_pre", pk(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_quiesce_post", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    // Recovery: a fresh request still runs the full sequence.
    issue(4'd8);
    check_seq(model_cur, 4'd8, 1'b0, LAT_SEL, "recover_8");
    model_cur = 4'd8;
    check_idle("recover_8_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
